riscv_fetch_unit: RTL

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_fetch_fifo.sv | 43 ++++
 rtl/riscv_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and PC helper used by the fetch path.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sequential instruction address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Instruction word buffer: data only, push/pop/flush, no full/empty tracking
// (the fetch unit owns occupancy and never overfills it).
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] storage [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) storage[wr_ptr] <= push_data;
    end

    assign head_data = storage[rd_ptr];

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction prefetcher: credit-limited in-order memory requests, a small
// instruction buffer, and redirect handling that drops stale in-flight reads.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] fetch_data,
    input  logic            fetch_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            err_unexpected
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   occ_count;
    logic [CW-1:0]   out_count;
    logic [CW-1:0]   drop_count;
    logic [CW-1:0]   out_next;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] pf_pc;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] stale_addr;
    logic [XLEN-1:0] head_data;
    logic            stale;
    logic            err_q;
    logic            req_accept;
    logic            resp_live;
    logic            do_push;
    logic            do_pop;

    // Buffered plus in-flight words may never exceed DEPTH; a stale request
    // must keep being offered until the memory takes it.
    assign credit_sum    = {1'b0, occ_count} + {1'b0, out_count};
    assign mem_req_valid = !reset && (stale || (credit_sum < (CW+1)'(DEPTH)));
    assign mem_req_addr  = stale ? stale_addr : pf_pc;
    assign req_accept    = mem_req_valid && mem_req_ready;

    assign resp_live = mem_resp_valid && (out_count != '0);
    assign do_push   = resp_live && (drop_count == '0) && !redirect;
    assign do_pop    = fetch_valid && fetch_ready && !redirect;
    assign out_next  = out_count + CW'(req_accept) - CW'(resp_live);

    assign fetch_valid    = (occ_count != '0);
    assign fetch_pc       = head_pc;
    assign fetch_data     = fetch_valid ? head_data : '0;
    assign err_unexpected = err_q;

    // Redirect wins over push/pop; everything still in flight afterwards is
    // dropped, including a held request that is accepted later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_count  <= '0;
            out_count  <= '0;
            drop_count <= '0;
            pf_pc      <= RESET_PC;
            head_pc    <= RESET_PC;
            stale_addr <= RESET_PC;
            stale      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            out_count <= out_next;
            if (mem_resp_valid && (out_count == '0)) err_q <= 1'b1;

            if (redirect) begin
                occ_count  <= '0;
                head_pc    <= redirect_pc;
                pf_pc      <= redirect_pc;
                drop_count <= out_next;
            end else begin
                occ_count  <= occ_count + CW'(do_push) - CW'(do_pop);
                drop_count <= drop_count - CW'(resp_live && (drop_count != '0))
                                         + CW'(req_accept && stale);
                if (do_pop) head_pc <= next_pc(head_pc);
                if (req_accept && !stale) pf_pc <= next_pc(pf_pc);
            end

            if (redirect && mem_req_valid && !mem_req_ready) begin
                stale      <= 1'b1;
                stale_addr <= mem_req_addr;
            end else if (req_accept) begin
                stale <= 1'b0;
            end
        end
    end

    riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (mem_resp_data),
        .head_data (head_data)
    );

endmodule
